mnist_ctrl_fsm: RTL and testbench
=================================

Name: mnist_ctrl_fsm

Overview:
- Sequencing controller for the MNIST 784-32-10 inference accelerator.
- On a start request it steps through: image load, layer-1 MAC sweep over 784 pixels, ReLU, layer-2 MAC sweep over 32 activations, and argmax.
- It drives row_idx, layer_sel and the strobes that the memory controller, MAC arrays, ReLU unit and argmax register consume.
- Pure control block with no datapath.

Parameters:
- IMG_SIZE, 784: layer-1 sweep length (pixels).
- HID_SIZE, 32: layer-2 sweep length (hidden activations).
- RELU_CYC, 2: cycles spent in the ReLU state (minimum 2).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  inference request; sampled in IDLE and DONE only.
- done  out  1  level; high while in DONE.
- busy  out  1  high in LOAD, L1, RELU, L2 and MAX.
- layer_sel  out  2  0 = none, 1 = layer 1, 2 = layer 2.
- row_idx  out  10  current pixel or activation index.
- mac_en_l1  out  1  layer-1 MAC accumulate enable.
- mac_clr_l1  out  1  layer-1 accumulator clear.
- mac_en_l2  out  1  layer-2 MAC accumulate enable.
- mac_clr_l2  out  1  layer-2 accumulator clear.
- load_img  out  1  capture image into the image buffer.
- comp_l1  out  1  layer-1 compute phase.
- apply_relu  out  1  ReLU phase.
- comp_l2  out  1  layer-2 compute phase.
- find_max  out  1  argmax capture strobe.
- cycle_cnt  out  10  busy-cycle counter (see Optional Feature).

Behaviour:
- Moore FSM. Outputs are decoded from the registered state and counters only, never from start.
- States: IDLE, LOAD, L1, RELU, L2, MAX, DONE.
- Reset: rst=0 at a clock edge forces IDLE, row_idx=0 and cycle_cnt=0. All outputs are 0 from the next cycle. This applies in any state, including mid-sweep; no partial completion occurs.
- IDLE: all outputs 0. start=1 leads to LOAD.
- LOAD (1 cycle): load_img=1, mac_clr_l1=1, layer_sel=1, row_idx=0. Always leads to L1.
- L1 (IMG_SIZE cycles): comp_l1=1, mac_en_l1=1, layer_sel=1.
  - row_idx runs 0, 1, ..., IMG_SIZE-1, incrementing by one per cycle.
  - When row_idx=IMG_SIZE-1 the next state is RELU and row_idx returns to 0. row_idx never reaches IMG_SIZE.
- RELU (RELU_CYC cycles): apply_relu=1, layer_sel=2, row_idx=0.
  - mac_clr_l2=1 on the first RELU cycle only.
  - apply_relu deasserts exactly as L2 begins; downstream latches activations on that falling edge.
- L2 (HID_SIZE cycles): comp_l2=1, mac_en_l2=1, layer_sel=2.
  - row_idx runs 0 to HID_SIZE-1. At HID_SIZE-1 the next state is MAX.
- MAX (1 cycle): find_max=1, layer_sel=0, row_idx=0. Always leads to DONE.
- DONE: done=1, busy=0, all other strobes 0.
  - Held until start=1, which goes directly to LOAD; done drops in that same transition.
- start while busy is ignored (not queued).
- Latency: with start sampled at edge E, DONE is entered at edge E+1+IMG_SIZE+RELU_CYC+HID_SIZE+1, which is E+820 with defaults.
- Mutual exclusion: at most one of load_img, comp_l1, apply_relu, comp_l2, find_max is high in any cycle. mac_en_l1 and mac_en_l2 are never high together.

Optional Feature:
- Macro MNIST_CTRL_CYCLE_CNT_EN.
- Defined:
  - cycle_cnt clears to 0 on entry to LOAD and increments every busy cycle.
  - It holds its value in DONE, which is 820 with defaults, and saturates at 1023.
  - It is 0 in IDLE after reset.
- Undefined: cycle_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package mnist_pkg holds:
  - IMG_SIZE, HID_SIZE, OUT_SIZE=10;
  - the state typedef (7 encodings);
  - layer_sel encodings LSEL_NONE, LSEL_L1 and LSEL_L2.
- One natural sub-module: mnist_row_counter.
  - Behaviour: 10-bit counter with clear, enable and a terminal-count flag at a programmable limit.
  - Use: reused for the L1 sweep, L2 sweep and RELU dwell.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, then rst=1 with start=0 for 10 cycles. All outputs stay 0 and row_idx=0.
2. Full run: a 1-cycle start pulse gives:
   - load_img for exactly 1 cycle;
   - comp_l1 for 784 cycles with row_idx 0 to 783 contiguous;
   - apply_relu for 2 cycles with mac_clr_l2 on the first;
   - comp_l2 for 32 cycles with row_idx 0 to 31;
   - find_max for 1 cycle;
   - done rising 820 cycles after start; cycle_cnt=820 when the macro is enabled.
3. Start while busy: start held high for all of L1. Sequence and timing are identical to test 2, with no restart.
4. Restart from DONE: hold done for 50 cycles, then pulse start. done falls and load_img=1 in the next cycle, and the second run matches test 2.
5. Mid-run reset: rst=0 at row_idx=400. The next cycle is IDLE with all outputs 0; a following start gives a clean full run.
6. Exclusivity check: throughout tests 2 to 5, assert one-hot-or-zero on the phase strobes, busy XOR done outside IDLE, and row_idx < 784 at all times.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST 784-32-10 sequencing controller.
package mnist_pkg;

  localparam int IMG_SIZE = 784;
  localparam int HID_SIZE = 32;
  localparam int OUT_SIZE = 10;
  localparam int RELU_CYC = 2;
  localparam int ROW_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_L1,
    S_RELU,
    S_L2,
    S_MAX,
    S_DONE
  } state_t;

  localparam logic [1:0] LSEL_NONE = 2'd0;
  localparam logic [1:0] LSEL_L1   = 2'd1;
  localparam logic [1:0] LSEL_L2   = 2'd2;

  typedef struct packed {
    logic       done;
    logic       busy;
    logic [1:0] lsel;
    logic       en1;
    logic       clr1;
    logic       en2;
    logic       load;
    logic       c1;
    logic       relu;
    logic       c2;
    logic       fmax;
  } ctrl_t;

  // Phase strobes owned by each state; the one-shot l2 clear lives elsewhere.
  function automatic ctrl_t ctrl_dec(input state_t s);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_LOAD: begin
        c.busy = 1'b1;
        c.lsel = LSEL_L1;
        c.load = 1'b1;
        c.clr1 = 1'b1;
      end
      S_L1: begin
        c.busy = 1'b1;
        c.lsel = LSEL_L1;
        c.c1   = 1'b1;
        c.en1  = 1'b1;
      end
      S_RELU: begin
        c.busy = 1'b1;
        c.lsel = LSEL_L2;
        c.relu = 1'b1;
      end
      S_L2: begin
        c.busy = 1'b1;
        c.lsel = LSEL_L2;
        c.c2   = 1'b1;
        c.en2  = 1'b1;
      end
      S_MAX: begin
        c.busy = 1'b1;
        c.lsel = LSEL_NONE;
        c.fmax = 1'b1;
      end
      S_DONE: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mnist_row_counter.sv
// Row / dwell counter with clear, enable and terminal count at a
// programmable limit.
module mnist_row_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_limit);

endmodule

// File: rtl/mnist_ctrl_fsm.sv
// Sequencing FSM for the MNIST inference accelerator.
// Define MNIST_CTRL_CYCLE_CNT_EN to build the busy-cycle counter.
module mnist_ctrl_fsm #(
  parameter int IMG_SIZE = mnist_pkg::IMG_SIZE,
  parameter int HID_SIZE = mnist_pkg::HID_SIZE,
  parameter int RELU_CYC = mnist_pkg::RELU_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [1:0] layer_sel,
  output logic [9:0] row_idx,
  output logic       mac_en_l1,
  output logic       mac_clr_l1,
  output logic       mac_en_l2,
  output logic       mac_clr_l2,
  output logic       load_img,
  output logic       comp_l1,
  output logic       apply_relu,
  output logic       comp_l2,
  output logic       find_max,
  output logic [9:0] cycle_cnt
);

  import mnist_pkg::*;

  localparam logic [9:0] L1_LIM = 10'(IMG_SIZE - 1);
  localparam logic [9:0] RL_LIM = 10'(RELU_CYC - 1);
  localparam logic [9:0] L2_LIM = 10'(HID_SIZE - 1);

  state_t     r_state;
  state_t     w_nxt;
  ctrl_t      r_ctrl;
  logic       r_clr2;
  logic [9:0] w_cnt;
  logic [9:0] w_limit;
  logic       w_tc;
  logic       w_sweep;

  always_comb begin
    w_nxt   = r_state;
    w_limit = '0;
    w_sweep = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_nxt = S_LOAD;
      S_LOAD: w_nxt = S_L1;
      S_L1: begin
        w_sweep = 1'b1;
        w_limit = L1_LIM;
        if (w_tc) w_nxt = S_RELU;
      end
      S_RELU: begin
        w_sweep = 1'b1;
        w_limit = RL_LIM;
        if (w_tc) w_nxt = S_L2;
      end
      S_L2: begin
        w_sweep = 1'b1;
        w_limit = L2_LIM;
        if (w_tc) w_nxt = S_MAX;
      end
      S_MAX:  w_nxt = S_DONE;
      S_DONE: if (start) w_nxt = S_LOAD;
      default: w_nxt = S_IDLE;
    endcase
  end

  // One counter serves both sweeps and the ReLU dwell.
  mnist_row_counter #(
    .W(10)
  ) u_row (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_sweep || w_tc),
    .i_en    (w_sweep),
    .i_limit (w_limit),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
      r_clr2  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ctrl  <= ctrl_dec(w_nxt);
      r_clr2  <= (w_nxt == S_RELU) && (r_state != S_RELU);
    end
  end

  assign done       = r_ctrl.done;
  assign busy       = r_ctrl.busy;
  assign layer_sel  = r_ctrl.lsel;
  assign mac_en_l1  = r_ctrl.en1;
  assign mac_clr_l1 = r_ctrl.clr1;
  assign mac_en_l2  = r_ctrl.en2;
  assign mac_clr_l2 = r_clr2;
  assign load_img   = r_ctrl.load;
  assign comp_l1    = r_ctrl.c1;
  assign apply_relu = r_ctrl.relu;
  assign comp_l2    = r_ctrl.c2;
  assign find_max   = r_ctrl.fmax;
  assign row_idx    = (r_state == S_RELU) ? '0 : w_cnt;

`ifdef MNIST_CTRL_CYCLE_CNT_EN
  logic [9:0] r_cyc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cyc <= '0;
    end else if (w_nxt == S_LOAD && !r_ctrl.busy) begin
      r_cyc <= '0;
    end else if (r_ctrl.busy && r_cyc != 10'h3FF) begin
      r_cyc <= r_cyc + 10'd1;
    end
  end

  assign cycle_cnt = r_cyc;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mnist_ctrl_fsm.sv
// Self-checking bench for mnist_ctrl_fsm: run-timeline model plus
// directed scenarios with literal expectations.
module tb_mnist_ctrl_fsm;

  localparam int IMG = 784;
  localparam int HID = 32;
  localparam int RLC = 2;
  localparam int RUN_LEN = 1 + IMG + RLC + HID + 1;
`ifdef MNIST_CTRL_CYCLE_CNT_EN
  localparam int EXP_CYC = 820;
`else
  localparam int EXP_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       done, busy;
  logic [1:0] layer_sel;
  logic [9:0] row_idx, cycle_cnt;
  logic       mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2;
  logic       load_img, comp_l1, apply_relu, comp_l2, find_max;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mnist_ctrl_fsm #(
    .IMG_SIZE(IMG),
    .HID_SIZE(HID),
    .RELU_CYC(RLC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .done(done), .busy(busy), .layer_sel(layer_sel),
    .row_idx(row_idx),
    .mac_en_l1(mac_en_l1), .mac_clr_l1(mac_clr_l1),
    .mac_en_l2(mac_en_l2), .mac_clr_l2(mac_clr_l2),
    .load_img(load_img), .comp_l1(comp_l1),
    .apply_relu(apply_relu), .comp_l2(comp_l2),
    .find_max(find_max), .cycle_cnt(cycle_cnt)
  );

  // Model: idle / running at offset p since LOAD entry / done.
  int m_mode = 0;
  int m_p    = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode  = 0;
      m_p     = 0;
      m_valid = 1'b1;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1;
        m_p    = 0;
      end
    end else begin
      m_p = m_p + 1;
      if (m_p == RUN_LEN) m_mode = 2;
    end
  end

  int c_ld, c_c1, c_rl, c_cl2, c_c2, c_mx, last_r1, last_r2;

  always @(negedge clk) begin
    if (m_valid) begin
      bit run, e_ld, e_c1, e_rl, e_c2, e_mx, e_cl2;
      int e_row, e_lsel, e_cyc;
      logic [32:0] g, e;
      run   = (m_mode == 1);
      e_ld  = run && m_p == 0;
      e_c1  = run && m_p >= 1 && m_p <= IMG;
      e_rl  = run && m_p > IMG && m_p <= IMG + RLC;
      e_cl2 = run && m_p == IMG + 1;
      e_c2  = run && m_p > IMG + RLC && m_p <= IMG + RLC + HID;
      e_mx  = run && m_p == RUN_LEN - 1;
      e_row = e_c1 ? m_p - 1 : e_c2 ? m_p - (IMG + RLC + 1) : 0;
      e_lsel = (e_ld || e_c1) ? 1 : (e_rl || e_c2) ? 2 : 0;
      e_cyc = 0;
      if (EXP_CYC != 0) e_cyc = run ? m_p : (m_mode == 2) ? EXP_CYC : 0;
      g = {done, busy, layer_sel, row_idx, mac_en_l1, mac_clr_l1,
           mac_en_l2, mac_clr_l2, load_img, comp_l1, apply_relu,
           comp_l2, find_max, cycle_cnt};
      e = {m_mode == 2, run, 2'(e_lsel), 10'(e_row), e_c1, e_ld,
           e_c2, e_cl2, e_ld, e_c1, e_rl, e_c2, e_mx, 10'(e_cyc)};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL model t=%0t p=%0d got=%h exp=%h", $time, m_p, g, e);
      end
      n_tests++;
      if ($countones({load_img, comp_l1, apply_relu, comp_l2, find_max}) > 1
          || (mac_en_l1 && mac_en_l2) || row_idx >= 10'(IMG)
          || (m_mode != 0 && !(busy ^ done))) begin
        n_fail++;
        $display("FAIL excl t=%0t got=%b exp=exclusive", $time,
                 {busy, done, load_img, comp_l1, apply_relu, comp_l2, find_max});
      end
    end
    if (load_img) begin
      c_ld = 0; c_c1 = 0; c_rl = 0; c_cl2 = 0; c_c2 = 0; c_mx = 0;
    end
    c_ld  += int'(load_img);
    c_c1  += int'(comp_l1);
    c_rl  += int'(apply_relu);
    c_cl2 += int'(mac_clr_l2);
    c_c2  += int'(comp_l2);
    c_mx  += int'(find_max);
    if (comp_l1) last_r1 = int'(row_idx);
    if (comp_l2) last_r2 = int'(row_idx);
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({done, busy, layer_sel, row_idx, mac_en_l1, mac_clr_l1,
                 mac_en_l2, mac_clr_l2, load_img, comp_l1, apply_relu,
                 comp_l2, find_max}) + int'(cycle_cnt);
  endfunction

  task automatic do_run(input string tag, input int hold);
    int k;
    start = 1'b1;
    step();
    k = 0;
    if (hold == 0) start = 1'b0;
    check({tag, "_load"}, int'(load_img), 1);
    check({tag, "_done0"}, int'(done), 0);
    while (!done && k < 900) begin
      step();
      k++;
      if (k >= hold) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, k, 820);
    check({tag, "_n_load"}, c_ld, 1);
    check({tag, "_n_l1"}, c_c1, 784);
    check({tag, "_last_r1"}, last_r1, 783);
    check({tag, "_n_relu"}, c_rl, 2);
    check({tag, "_n_clr2"}, c_cl2, 1);
    check({tag, "_n_l2"}, c_c2, 32);
    check({tag, "_last_r2"}, last_r2, 31);
    check({tag, "_n_max"}, c_mx, 1);
    check({tag, "_cyc"}, int'(cycle_cnt), EXP_CYC);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    check("idle_zero", outs(), 0);
    check("idle_row", int'(row_idx), 0);

    do_run("run1", 0);

    step();
    do_run("busy_start", 785);

    repeat (50) step();
    check("done_hold", int'(done), 1);
    do_run("restart", 0);

    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(comp_l1 && row_idx == 10'd400) && k < 900) begin
      step();
      k++;
    end
    check("reach_400", int'(row_idx), 400);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_zero", outs(), 0);
    step();
    check("midrst_idle", outs(), 0);
    do_run("after_rst", 0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
